// File: rtl/seq_multiplier_if.sv
// ============================================================================
// Module   : seq_multiplier_if
// Purpose  : Operand/result handshake bundle for the sequential multiplier.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface seq_multiplier_if #(
  parameter int WIDTH = 8
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a_in;
  logic [WIDTH-1:0]     b_in;
  logic                 signed_mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;

  modport master (
    output in_valid, a_in, b_in, signed_mode, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a_in, b_in, signed_mode, out_ready,
    output in_ready, out_valid, product, busy
  );

endinterface

`default_nettype wire

// File: rtl/seq_multiplier.sv
// ============================================================================
// Module   : seq_multiplier
// Purpose  : Fixed-latency shift-add multiplier, signed or unsigned operands.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module seq_multiplier #(
  parameter int WIDTH     = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  wire logic        clk,
  input  wire logic        reset,
  seq_multiplier_if.slave  bus
);

  localparam int                     c_cnt_w    = $clog2(WIDTH + 1);
  localparam logic [c_cnt_w-1:0]     c_cnt_last = c_cnt_w'(WIDTH);
  localparam logic [c_cnt_w-1:0]     c_cnt_one  = {{(c_cnt_w-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]       c_one_w    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0]     c_one_2w   = {{(2*WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_product;
  logic                 r_neg;
  logic [c_cnt_w-1:0]   r_count;

  logic                 w_mode;
  logic                 w_a_neg;
  logic                 w_b_neg;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic [WIDTH-1:0]     w_addend;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_acc_step;
  logic [2*WIDTH-1:0]   w_final;

  // Magnitude of the most negative value wraps to 2^(WIDTH-1), which is exact unsigned.
  always_comb begin
    w_mode   = bus.signed_mode & SIGNED_EN;
    w_a_neg  = w_mode & bus.a_in[WIDTH-1];
    w_b_neg  = w_mode & bus.b_in[WIDTH-1];
    w_a_mag  = w_a_neg ? (~bus.a_in + c_one_w) : bus.a_in;
    w_b_mag  = w_b_neg ? (~bus.b_in + c_one_w) : bus.b_in;
  end

  always_comb begin
    w_addend   = r_mplier[0] ? r_mcand : '0;
    w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
    w_acc_step = {w_sum, r_acc[WIDTH-1:1]};
    w_final    = (r_neg && (r_acc != '0)) ? (~r_acc + c_one_2w) : r_acc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.in_valid)           w_state_nxt = S_CALC;
      S_CALC:  if (r_count == c_cnt_last)  w_state_nxt = S_DONE;
      S_DONE:  if (bus.out_ready)          w_state_nxt = S_IDLE;
      default:                             w_state_nxt = S_IDLE;
    endcase
  end

  // WIDTH shift-add steps, then one finalize cycle that applies the sign.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_product <= '0;
      r_neg     <= 1'b0;
      r_count   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_mcand  <= w_a_mag;
            r_mplier <= w_b_mag;
            r_neg    <= w_a_neg ^ w_b_neg;
            r_acc    <= '0;
            r_count  <= '0;
          end
        end
        S_CALC: begin
          if (r_count != c_cnt_last) begin
            r_acc    <= w_acc_step;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + c_cnt_one;
          end else begin
            r_product <= w_final;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.busy      = (r_state == S_CALC) || (r_state == S_DONE);
  assign bus.product   = r_product;

endmodule

`default_nettype wire

// File: tb/tb_seq_multiplier.sv
// ============================================================================
// Module   : tb_seq_multiplier
// Purpose  : Scoreboard bench for seq_multiplier (signed and unsigned builds).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_seq_multiplier;

  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_multiplier_if #(.WIDTH(W)) mif   ();
  seq_multiplier_if #(.WIDTH(W)) mif_u ();

  seq_multiplier #(.WIDTH(W), .SIGNED_EN(1'b1)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mif.slave)
  );

  seq_multiplier #(.WIDTH(W), .SIGNED_EN(1'b0)) u_dut_u (
    .clk   (clk),
    .reset (reset),
    .bus   (mif_u.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [2*W-1:0] sb_q[$];

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sm, input logic sen);
    logic signed [2*W-1:0] sa;
    logic signed [2*W-1:0] sb;
    logic signed [2*W-1:0] sp;
    if (sm && sen) begin
      sa = $signed({{W{a[W-1]}}, a});
      sb = $signed({{W{b[W-1]}}, b});
      sp = sa * sb;
      return sp;
    end
    return {{W{1'b0}}, a} * {{W{1'b0}}, b};
  endfunction

  // Result handshake happens on the next rising edge; compare against the oldest entry.
  always @(negedge clk) begin
    if (!reset && mif.out_valid && mif.out_ready) begin
      if (sb_q.size() == 0) check_eq("unexpected_out", 1, 0);
      else                  check_eq("product", mif.product, sb_q.pop_front());
    end
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                        input bit scramble, input bit pulse, input int hold);
    int lat;
    bit got;
    logic [2*W-1:0] p0;
    mif.a_in        = a;
    mif.b_in        = b;
    mif.signed_mode = sm;
    mif.in_valid    = 1'b1;
    mif.out_ready   = (hold == 0);
    @(negedge clk);
    check_eq("in_ready_idle", mif.in_ready, 1);
    sb_q.push_back(model(a, b, sm, 1'b1));
    @(posedge clk); #1;
    mif.in_valid = 1'b0;
    if (scramble) begin
      mif.a_in        = ~a;
      mif.b_in        = b ^ 8'h5A;
      mif.signed_mode = ~sm;
    end
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      if (pulse && lat == 3) begin
        mif.in_valid = 1'b1;
        mif.a_in     = 8'h11;
        mif.b_in     = 8'h22;
      end else begin
        mif.in_valid = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      if (lat == 4) check_eq("calc_flags", {mif.in_ready, mif.busy, mif.out_valid}, 3'b010);
      if (mif.out_valid) got = 1'b1;
    end
    mif.in_valid = 1'b0;
    check_eq("latency", lat, 9);
    if (got && hold > 0) begin
      p0 = mif.product;
      repeat (hold) begin
        @(posedge clk); #1;
        check_eq("hold", {mif.out_valid, mif.in_ready, mif.product}, {1'b1, 1'b0, p0});
      end
      mif.out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check_eq("back_idle", {mif.in_ready, mif.out_valid, mif.busy}, 3'b100);
  endtask

  initial begin
    int lat_u;
    logic [W-1:0] ra, rb;
    logic rs;

    reset           = 1'b1;
    mif.in_valid    = 1'b0;
    mif.a_in        = '0;
    mif.b_in        = '0;
    mif.signed_mode = 1'b0;
    mif.out_ready   = 1'b1;
    mif_u.in_valid    = 1'b0;
    mif_u.a_in        = '0;
    mif_u.b_in        = '0;
    mif_u.signed_mode = 1'b0;
    mif_u.out_ready   = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_state", {mif.in_ready, mif.out_valid, mif.busy, mif.product},
             {3'b100, 16'h0000});
    reset = 1'b0;

    run_op(8'hFF, 8'hFF, 1'b0, 0, 0, 0);
    run_op(8'h80, 8'h80, 1'b1, 0, 0, 0);
    run_op(8'h80, 8'h01, 1'b1, 0, 0, 0);
    run_op(8'hFD, 8'h05, 1'b1, 0, 0, 0);
    run_op(8'h00, 8'h37, 1'b0, 0, 0, 5);
    run_op(8'h12, 8'h34, 1'b0, 0, 1, 0);
    run_op(8'hF3, 8'h7F, 1'b1, 1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom_range(0, 1));
      run_op(ra, rb, rs, 0, 0, 0);
    end

    // Abort an operation on its 4th CALC cycle.
    mif.a_in        = 8'h33;
    mif.b_in        = 8'h44;
    mif.signed_mode = 1'b0;
    mif.in_valid    = 1'b1;
    @(posedge clk); #1;
    mif.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_eq("reset_abort", {mif.in_ready, mif.out_valid, mif.busy, mif.product},
             {3'b100, 16'h0000});
    @(posedge clk); #1;
    reset = 1'b0;
    run_op(8'h0C, 8'h0A, 1'b0, 0, 0, 0);

    // Unsigned-only build ignores signed_mode.
    mif_u.a_in        = 8'hFF;
    mif_u.b_in        = 8'h02;
    mif_u.signed_mode = 1'b1;
    mif_u.in_valid    = 1'b1;
    @(posedge clk); #1;
    mif_u.in_valid = 1'b0;
    lat_u = 0;
    while (!mif_u.out_valid && lat_u < 20) begin
      @(posedge clk); #1;
      lat_u++;
    end
    check_eq("u_latency", lat_u, 9);
    check_eq("u_product", mif_u.product, 16'h01FE);

    repeat (2) @(posedge clk);
    check_eq("sb_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
